// File: rtl/mem_arbiter_if.sv
// Memory-side request/done handshake between the arbiter (master) and the
// unified memory model (slave).
interface mem_arbiter_if;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serializes fetch and data requests onto one
// memory handshake, data first, with a starvation guard for fetch.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [15:0]   if_addr,
  output logic [15:0]   if_data,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [15:0]   dm_addr,
  input  logic [15:0]   dm_wdata,
  output logic [15:0]   dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  input  logic          halt,
  output logic          busy,
  mem_arbiter_if.master mem
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_BUSY = 3'd1,
    DM_BUSY = 3'd2,
    IF_DONE = 3'd3,
    DM_DONE = 3'd4
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state_r;
  logic [3:0] starve_cnt_r;
  logic       if_elig_s;
  logic       grant_dm_s;
  logic       grant_if_s;

  // Winner selection for the IDLE cycle: data first unless fetch has starved.
  always_comb begin
    if_elig_s  = if_req & ~halt;
    grant_dm_s = dm_req & ~(if_elig_s & (starve_cnt_r == STARVE_LIM));
    grant_if_s = if_elig_s & ~grant_dm_s;
  end

  // Stalls drop in the done cycle so the pipeline consumes data on that edge.
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  // Arbiter FSM with registered memory launch, completion and data outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= IDLE;
      starve_cnt_r  <= 4'd0;
      mem.mem_en    <= 1'b0;
      mem.mem_wr    <= 1'b0;
      mem.mem_addr  <= 16'h0000;
      mem.mem_wdata <= 16'h0000;
      if_data       <= 16'h0000;
      dm_rdata      <= 16'h0000;
      if_done       <= 1'b0;
      dm_done       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      mem.mem_en <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_dm_s) begin
            state_r       <= DM_BUSY;
            busy          <= 1'b1;
            mem.mem_en    <= 1'b1;
            mem.mem_wr    <= dm_wr;
            mem.mem_addr  <= dm_addr;
            mem.mem_wdata <= dm_wdata;
          end else if (grant_if_s) begin
            state_r      <= IF_BUSY;
            busy         <= 1'b1;
            mem.mem_en   <= 1'b1;
            mem.mem_wr   <= 1'b0;
            mem.mem_addr <= if_addr;
          end
          // Only a data grant over a waiting fetch advances the guard.
          if (!if_elig_s || grant_if_s) begin
            starve_cnt_r <= 4'd0;
          end else if (starve_cnt_r != STARVE_LIM) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
          end
        end
        IF_BUSY: begin
          if (mem.mem_done) begin
            if_data <= mem.mem_rdata;
            if_done <= 1'b1;
            state_r <= IF_DONE;
          end
        end
        DM_BUSY: begin
          if (mem.mem_done) begin
            if (!mem.mem_wr) begin
              dm_rdata <= mem.mem_rdata;
            end
            dm_done <= 1'b1;
            state_r <= DM_DONE;
          end
        end
        IF_DONE: begin
          if_done <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        DM_DONE: begin
          dm_done <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          if_done <= 1'b0;
          dm_done <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized phase checked against a transaction-level model.
module tb_mem_arbiter;
  localparam int STARVE_MAX = 4;
  localparam logic [1:0] K_IF = 2'd0;
  localparam logic [1:0] K_LD = 2'd1;
  localparam logic [1:0] K_ST = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0000;
  logic [15:0] if_data;
  logic        if_done;
  logic        if_stall;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = 16'h0000;
  logic [15:0] dm_wdata = 16'h0000;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        halt = 1'b0;
  logic        busy;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data),
    .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .halt(halt), .busy(busy), .mem(bus)
  );

  always #5 clk = ~clk;

  // Memory model: latency lat cycles from the mem_en cycle to mem_done.
  logic [15:0] mem [0:255];
  int          lat = 1;
  logic        pend;
  int          cnt;
  logic [7:0]  ma;
  logic        mw;
  logic [15:0] mwd;
  logic        md;
  logic [15:0] mrd;
  logic        spur = 1'b0;

  assign bus.mem_done  = md | spur;
  assign bus.mem_rdata = mrd;

  always @(negedge clk) begin
    md <= 1'b0;
    if (pend) begin
      if (cnt == 1) begin
        md   <= 1'b1;
        pend <= 1'b0;
        if (mw) begin
          mem[ma] <= mwd;
          mrd     <= 16'hDEAD;
        end else begin
          mrd <= mem[ma];
        end
      end
      cnt <= cnt - 1;
    end
    if (bus.mem_en) begin
      pend <= 1'b1;
      cnt  <= lat;
      ma   <= bus.mem_addr[7:0];
      mw   <= bus.mem_wr;
      mwd  <= bus.mem_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  // One isolated transaction starting at the current negedge (cycle 0).
  task automatic run_vec(input vec_t v);
    lat = v.lat;
    if (v.kind == K_IF) begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end else begin
      dm_req   = 1'b1;
      dm_wr    = (v.kind == K_ST);
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
    end
    #1;
    chk1("vec_stall_c0", (v.kind == K_IF) ? if_stall : dm_stall, 1'b1);
    for (int k = 1; k <= v.lat + 3; k++) begin
      @(negedge clk);
      chk1("vec_mem_en", bus.mem_en, k == 1);
      chk1("vec_busy", busy, (k >= 1) && (k <= v.lat + 2));
      chk1("vec_if_done", if_done, (v.kind == K_IF) && (k == v.lat + 2));
      chk1("vec_dm_done", dm_done, (v.kind != K_IF) && (k == v.lat + 2));
      if (k == 1) begin
        chk16("vec_mem_addr", bus.mem_addr, v.addr);
        chk1("vec_mem_wr", bus.mem_wr, v.kind == K_ST);
        if (v.kind == K_ST) chk16("vec_mem_wdata", bus.mem_wdata, v.wdata);
      end
      if (k == v.lat + 2) begin
        if (v.kind == K_IF) begin
          chk16("vec_if_data", if_data, v.exp);
          chk1("vec_if_stall_done", if_stall, 1'b0);
        end else begin
          chk16("vec_dm_rdata", dm_rdata, v.exp);
          chk1("vec_dm_stall_done", dm_stall, 1'b0);
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        dm_wr  = 1'b0;
      end
    end
  endtask

  initial begin : main
    int          n;
    int          cyc;
    int          launches;
    logic        seen;
    logic [15:0] got_addr;
    logic [15:0] got [10];
    logic [15:0] shadow [0:255];
    logic        idle_prev, idle_c, done_c, exp_launch, win_dm;
    logic        active, t_is_if, t_wr;
    logic [15:0] t_addr, t_wdata, last_if, last_rd;
    int          lc, tlat, starve;
    logic        p_if_elig, p_dm, p_dm_wr;
    logic [15:0] p_if_addr, p_dm_addr, p_dm_wdata;

    pend <= 1'b0;
    for (int i = 0; i < 256; i++) mem[i] <= {8'h5A, 8'(i)};
    mem[8'h40] <= 16'hBEEF;
    mem[8'h20] <= 16'hCAFE;
    mem[8'h21] <= 16'h0F0F;

    vecs[0] = '{K_LD, 16'h0040, 16'h0000, 2, 16'hBEEF};
    vecs[1] = '{K_ST, 16'h0010, 16'h1234, 1, 16'hBEEF};
    vecs[2] = '{K_LD, 16'h0010, 16'h0000, 3, 16'h1234};
    vecs[3] = '{K_IF, 16'h0020, 16'h0000, 1, 16'hCAFE};
    vecs[4] = '{K_IF, 16'h0021, 16'h0000, 4, 16'h0F0F};
    vecs[5] = '{K_LD, 16'h0021, 16'h0000, 1, 16'h0F0F};
    vecs[6] = '{K_ST, 16'h0021, 16'h5555, 2, 16'h0F0F};
    vecs[7] = '{K_IF, 16'h0021, 16'h0000, 2, 16'h5555};

    // Reset state.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_mem_wr", bus.mem_wr, 1'b0);
    chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk16("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    chk16("rst_if_data", if_data, 16'h0000);
    chk16("rst_dm_rdata", dm_rdata, 16'h0000);
    chk1("rst_if_done", if_done, 1'b0);
    chk1("rst_dm_done", dm_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Contention: data first, fetch on the next IDLE.
    lat = 1;
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0040;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk1("cont_mem_en", bus.mem_en, (k == 1) || (k == 5));
      if (k == 1) chk16("cont_addr_dm", bus.mem_addr, 16'h0040);
      if (k == 5) chk16("cont_addr_if", bus.mem_addr, 16'h0020);
      chk1("cont_dm_done", dm_done, k == 3);
      chk1("cont_if_done", if_done, k == 7);
      if (k <= 7) chk1("cont_if_stall", if_stall, k <= 6);
      if (k == 3) begin
        chk16("cont_dm_rdata", dm_rdata, 16'hBEEF);
        dm_req = 1'b0;
      end
      if (k == 7) begin
        chk16("cont_if_data", if_data, 16'hCAFE);
        if_req = 1'b0;
      end
    end

    // Starvation guard: every fifth grant goes to the waiting fetch.
    lat = 1;
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0040;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_en) begin
        got[n] = bus.mem_addr;
        n++;
      end
    end
    chk16("starve_grant_count", 16'(n), 16'd10);
    for (int i = 0; i < 10; i++)
      chk16("starve_order", got[i], (i % (STARVE_MAX + 1) == STARVE_MAX) ? 16'h0020 : 16'h0040);
    if_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (dm_done) seen = 1'b1;
    end
    chk1("starve_last_done", seen, 1'b1);
    dm_req = 1'b0;
    @(negedge clk);

    // Halt blocks fetch grants but not data.
    halt = 1'b1; if_req = 1'b1; if_addr = 16'h0022;
    launches = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_en) launches++;
    end
    chk16("halt_no_launch", 16'(launches), 16'd0);
    chk1("halt_idle", busy, 1'b0);
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0041;
    launches = 0; seen = 1'b0; got_addr = 16'h0000;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        launches++;
        got_addr = bus.mem_addr;
      end
      if (dm_done) seen = 1'b1;
    end
    chk1("halt_dm_done", seen, 1'b1);
    chk16("halt_dm_launches", 16'(launches), 16'd1);
    chk16("halt_dm_addr", got_addr, 16'h0041);
    chk16("halt_dm_rdata", dm_rdata, 16'h5A41);
    dm_req = 1'b0;

    // Halt raised during IF_BUSY: the fetch finishes, no new fetch grant.
    halt = 1'b0; lat = 4;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        seen = 1'b1;
        got_addr = bus.mem_addr;
      end
    end
    chk1("hmid_launch", seen, 1'b1);
    chk16("hmid_addr", got_addr, 16'h0022);
    halt = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (if_done) seen = 1'b1;
    end
    chk1("hmid_if_done", seen, 1'b1);
    chk16("hmid_if_data", if_data, 16'h5A22);
    launches = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.mem_en) launches++;
    end
    chk16("hmid_no_regrant", 16'(launches), 16'd0);
    if_req = 1'b0; halt = 1'b0;
    @(negedge clk);

    // Reset in DM_BUSY; the late mem_done must be ignored.
    lat = 2;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0040;
    @(negedge clk);
    chk1("rmid_launch", bus.mem_en, 1'b1);
    @(negedge clk);
    rst = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      chk1("rmid_busy", busy, 1'b0);
      chk1("rmid_dm_done", dm_done, 1'b0);
      chk1("rmid_mem_en", bus.mem_en, 1'b0);
      chk16("rmid_dm_rdata", dm_rdata, 16'h0000);
      @(negedge clk);
    end

    // Randomized traffic against a transaction-level model.
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    idle_prev = 1'b1; active = 1'b0; starve = 0;
    last_if = 16'h0000; last_rd = 16'h0000;
    p_if_elig = 1'b0; p_dm = 1'b0; p_dm_wr = 1'b0;
    p_if_addr = 16'h0000; p_dm_addr = 16'h0000; p_dm_wdata = 16'h0000;
    t_is_if = 1'b0; t_wr = 1'b0; t_addr = 16'h0000; t_wdata = 16'h0000;
    lc = 0; tlat = 1; lat = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      spur = 1'b0;
      if (idle_prev) begin
        exp_launch = p_if_elig || p_dm;
        chk1("rnd_launch", bus.mem_en, exp_launch);
        if (exp_launch) begin
          win_dm = p_dm && !(p_if_elig && starve == STARVE_MAX);
          if (win_dm) begin
            chk16("rnd_dm_addr", bus.mem_addr, p_dm_addr);
            chk1("rnd_dm_wr", bus.mem_wr, p_dm_wr);
            if (p_dm_wr) chk16("rnd_dm_wdata", bus.mem_wdata, p_dm_wdata);
            starve = p_if_elig ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
          end else begin
            chk16("rnd_if_addr", bus.mem_addr, p_if_addr);
            chk1("rnd_if_wr", bus.mem_wr, 1'b0);
            starve = 0;
          end
          active  = 1'b1;
          lc      = c;
          tlat    = lat;
          t_is_if = !win_dm;
          t_wr    = win_dm && p_dm_wr;
          t_addr  = win_dm ? p_dm_addr : p_if_addr;
          t_wdata = p_dm_wdata;
        end else begin
          starve = 0;
        end
      end else begin
        chk1("rnd_no_launch", bus.mem_en, 1'b0);
      end
      idle_c = !active;
      chk1("rnd_busy", busy, !idle_c);
      done_c = active && (c == lc + tlat + 1);
      chk1("rnd_if_done", if_done, done_c && t_is_if);
      chk1("rnd_dm_done", dm_done, done_c && !t_is_if);
      chk1("rnd_if_stall", if_stall, if_req && !(done_c && t_is_if));
      chk1("rnd_dm_stall", dm_stall, dm_req && !(done_c && !t_is_if));
      if (done_c) begin
        if (t_is_if) begin
          last_if = shadow[t_addr[7:0]];
          if_req  = 1'b0;
        end else begin
          if (t_wr) shadow[t_addr[7:0]] = t_wdata;
          else      last_rd = shadow[t_addr[7:0]];
          dm_req = 1'b0;
        end
        active = 1'b0;
        lat = $urandom_range(1, 4);
      end
      chk16("rnd_if_data", if_data, last_if);
      chk16("rnd_dm_rdata", dm_rdata, last_rd);

      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1'b1;
        if_addr = 16'h0020 + 16'($urandom_range(0, 15));
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req   = 1'b1;
        dm_wr    = 1'($urandom_range(0, 1));
        dm_addr  = 16'h0040 + 16'($urandom_range(0, 15));
        dm_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 15) == 0) halt = !halt;
      if ((idle_c || done_c) && $urandom_range(0, 5) == 0) spur = 1'b1;
      p_if_elig  = if_req && !halt;
      p_dm       = dm_req;
      p_dm_wr    = dm_wr;
      p_if_addr  = if_addr;
      p_dm_addr  = dm_addr;
      p_dm_wdata = dm_wdata;
      idle_prev  = idle_c;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
